// File: rtl/div_pkg.sv
// Shared types and constants for the sequential unsigned divider.
// Holds the FSM state encoding, the divide-by-zero quotient and the counter sizing helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wide enough for any supported WIDTH; users slice off the low WIDTH bits.
    localparam int MAX_WIDTH = 1024;
    localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/divu_1iter.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// trial-subtract the divisor and shift the resulting quotient bit into the quotient.
module divu_1iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   diff;
    logic             take;

    assign shifted = {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign diff    = {1'b0, shifted} - {1'b0, divisor};

    // The bit shifted out of rem is an implicit 2^WIDTH: if set, the shifted value
    // certainly exceeds the divisor and the low WIDTH bits of diff are the true result.
    assign take     = rem[WIDTH-1] | ~diff[WIDTH];
    assign next_rem = take ? diff[WIDTH-1:0] : shifted;
    assign next_quo = {quo[WIDTH-2:0], take};

endmodule

// File: rtl/seq_divider_unsigned.sv
// Iterative restoring unsigned divider with valid/ready handshakes on both sides.
// One quotient bit per cycle; divide-by-zero returns all-ones quotient and the dividend.
module seq_divider_unsigned
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, quo_q, divisor_q;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             dbz_q;
    logic             accept;

    assign accept = in_valid && in_ready;

    divu_1iter #(.WIDTH(WIDTH)) u_iter (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .next_rem (rem_nxt),
        .next_quo (quo_nxt)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)         state_d = (i_divisor == '0) ? DONE : BUSY;
            BUSY: if (cnt_q == '0)    state_d = DONE;
            DONE: if (out_ready)      state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // NOTE: the datapath is reset too, so outputs read as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        divisor_q <= i_divisor;
                        cnt_q     <= CNT_W'(WIDTH - 1);
                        if (i_divisor == '0) begin
                            quo_q <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
                            rem_q <= i_dividend;
                            dbz_q <= 1'b1;
                        end else begin
                            quo_q <= i_dividend;
                            rem_q <= '0;
                            dbz_q <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_quotient    = quo_q;
    assign o_remainder   = rem_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_unsigned.sv
// Self-checking bench for seq_divider_unsigned (WIDTH=32): directed cases, backpressure,
// asynchronous reset mid-operation and a short random regression against a scoreboard.
module tb_seq_divider_unsigned;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_divider_unsigned #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic issue(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        check({tag, "_in_ready"}, W'(in_ready), W'(1));
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        sb.push_back(model(a, b));
        step();
        in_valid = 1'b0;
    endtask

    // Waits for the result, checks latency/value, then stalls and consumes it.
    task automatic collect(input string tag, input int lat, input int stall);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        check({tag, "_out_valid"}, W'(out_valid), W'(1));
        e = sb.pop_front();
        if (!out_valid) return;
        if (lat > 0) check({tag, "_latency"}, W'(n + 1), W'(lat));
        check({tag, "_q"},   quotient,         e.q);
        check({tag, "_r"},   remainder,        e.r);
        check({tag, "_dbz"}, W'(div_by_zero),  W'(e.dbz));
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            dividend = $urandom;
            divisor  = $urandom;
            in_valid = 1'b1;
            step();
            check({tag, "_hold_valid"}, W'(out_valid), W'(1));
            check({tag, "_hold_ready"}, W'(in_ready),  W'(0));
            check({tag, "_hold_q"},     quotient,      e.q);
            check({tag, "_hold_r"},     remainder,     e.r);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check({tag, "_consumed"}, W'(out_valid), W'(0));
        check({tag, "_idle"},     W'(in_ready),  W'(1));
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int stall);
        issue(tag, a, b);
        collect(tag, (b == '0) ? 1 : W + 1, stall);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        #3;
        check("rst_in_ready",  W'(in_ready),     W'(1));
        check("rst_out_valid", W'(out_valid),    W'(0));
        check("rst_q",         quotient,         '0);
        check("rst_r",         remainder,        '0);
        check("rst_dbz",       W'(div_by_zero),  '0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_div("basic",     32'd100,        32'd7,          0);
        run_div("dbz",       32'hDEADBEEF,   32'd0,          0);
        run_div("ff_by_1",   32'hFFFFFFFF,   32'd1,          0);
        run_div("ff_by_ff",  32'hFFFFFFFF,   32'hFFFFFFFF,   0);
        run_div("small_big", 32'd5,          32'h80000000,   0);
        run_div("ovf_rem",   32'hFFFFFFFF,   32'h80000001,   0);

        // Backpressure: ten stalled cycles with ignored operands on the input.
        run_div("bp",        32'd1000,       32'd33,         10);

        // Asynchronous reset in the middle of BUSY.
        issue("rst_mid", 32'd12345, 32'd67);
        repeat (15) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", W'(out_valid),   W'(0));
        check("mid_rst_in_ready",  W'(in_ready),    W'(1));
        check("mid_rst_q",         quotient,        '0);
        check("mid_rst_r",         remainder,       '0);
        check("mid_rst_dbz",       W'(div_by_zero), '0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_idle", W'(out_valid), W'(0));
        run_div("post_rst", 32'd81, 32'd9, 0);

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 2))
                0:       rb = $urandom;
                1:       rb = $urandom >> $urandom_range(1, 31);
                default: rb = W'($urandom_range(0, 3));
            endcase
            run_div("rand", ra, rb, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
